// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - diagonal skew feeder for the systolic array operand inputs
// Lane i delays slices by i cycles; a tile ends with an N-1 cycle zero flush and a done pulse.
module systolic_feeder #(
  parameter int SYS_ARRAY_SIZE = 4,
  parameter int DATA_W         = 8,
  parameter int MAX_K          = 64,
  localparam int KW            = $clog2(MAX_K + 1),
  localparam int FW            = $clog2(SYS_ARRAY_SIZE)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   valid_i,
  input  logic                                   last_i,
  input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  a_vec_i,
  input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  b_vec_i,
  output logic                                   ready_o,
  output logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  a_o,
  output logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  b_o,
  output logic                                   busy_o,
  output logic [KW-1:0]                          k_cnt_o,
  output logic                                   tile_done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q;
  logic [KW-1:0]   k_cnt_q;
  logic            done_q;
  logic            acc;
  logic            end_tile;

  assign ready_o  = (state_q != FLUSH);
  assign acc      = valid_i & ready_o;
  // Hitting MAX_K ends the tile exactly as if last_i had been set.
  assign end_tile = last_i | (k_cnt_q == KW'(MAX_K - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = end_tile ? FLUSH : STREAM;
      STREAM:  if (acc && end_tile) state_d = FLUSH;
      FLUSH:   if (flush_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      k_cnt_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FLUSH) && (flush_cnt_q == '0);
      if (state_q != FLUSH && state_d == FLUSH)
        flush_cnt_q <= FW'(SYS_ARRAY_SIZE - 2);
      else if (state_q == FLUSH)
        flush_cnt_q <= flush_cnt_q - 1'b1;
      if (state_q == FLUSH && state_d == IDLE)
        k_cnt_q <= '0;
      else if (acc)
        k_cnt_q <= k_cnt_q + 1'b1;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign k_cnt_o     = k_cnt_q;
  assign tile_done_o = done_q & (state_q == IDLE);

  for (genvar i = 0; i < SYS_ARRAY_SIZE; i++) begin : g_lane
    logic [i:0][DATA_W-1:0] a_ch;
    logic [i:0][DATA_W-1:0] b_ch;

    // Chains shift every cycle; non-accepted cycles inject zero bubbles.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        a_ch <= '0;
        b_ch <= '0;
      end else begin
        a_ch[0] <= acc ? a_vec_i[i] : '0;
        b_ch[0] <= acc ? b_vec_i[i] : '0;
        for (int j = 1; j <= i; j++) begin
          a_ch[j] <= a_ch[j-1];
          b_ch[j] <= b_ch[j-1];
        end
      end
    end

    assign a_o[i] = a_ch[i];
    assign b_o[i] = b_ch[i];
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream operand stage for `systolic_array`. Accepts one k-slice per beat over a valid/ready handshake: a column of A and a row of B, `SYS_ARRAY_SIZE` elements each. It emits the diagonally skewed `a_o`/`b_o` vectors that drive the array's `a_i`/`b_i` inputs, with lane i delayed i cycles relative to lane 0. Bubbles are filled with zeros, and after the last slice of a tile the feeder flushes the skew pipeline and pulses `tile_done_o`, so the drain side knows the operand stream is complete.

## Interface
- `SYS_ARRAY_SIZE`, default: common_pkg `SYS_ARRAY_SIZE`. Lane count N; N ≥ 2 is required.
- `MAX_K`, default 64. Maximum number of slices per tile; MAX_K ≥ 1.
- `clk_i`  in  1  Clock; all state updates on the rising edge.
- `rst_i`  in  1  Reset, asynchronous, active-high.
- `valid_i`  in  1  A slice is presented on `a_vec_i`/`b_vec_i`.
- `last_i`  in  1  The presented slice is the last of the tile; qualified by `valid_i`.
- `a_vec_i`  in  `matrix_data_t [N-1:0]`  A column k, where element i feeds row i.
- `b_vec_i`  in  `matrix_data_t [N-1:0]`  B row k, where element j feeds column j.
- `ready_o`  out  1  The feeder accepts a slice this cycle.
- `a_o`  out  `matrix_data_t [N-1:0]`  Skewed A lanes, connected to `systolic_array.a_i`.
- `b_o`  out  `matrix_data_t [N-1:0]`  Skewed B lanes, connected to `systolic_array.b_i`.
- `busy_o`  out  1  State is not IDLE.
- `k_cnt_o`  out  `$clog2(MAX_K+1)`  Slices accepted in the current tile.
- `tile_done_o`  out  1  Single-cycle pulse when the final slice's lane N-1 element is on `b_o`/`a_o`.

## Operation
- Accept condition: `acc = valid_i & ready_o`. `ready_o` is 1 in IDLE and STREAM, and 0 in FLUSH.
- Skew datapath, lane i (both A and B):
  - The lane is a chain of i+1 registers, and it shifts on every cycle regardless of handshake.
  - The chain input is `a_vec_i[i]`/`b_vec_i[i]` when `acc`; otherwise it is `'0`.
  - There is no downstream backpressure: the array consumes every cycle.
- Zero bubbles are arithmetically neutral in the MACs. An idle `valid_i` mid-tile is therefore legal and only delays the result.
- FSM:
  - IDLE → STREAM on `acc & ~last_i`.
  - IDLE → FLUSH on `acc & last_i`.
  - STREAM → FLUSH on `acc & (last_i | k_cnt_o == MAX_K-1)`. Reaching MAX_K is a forced end of tile, treated exactly as `last_i`.
  - STREAM stays in STREAM otherwise, including while `valid_i` = 0.
  - FLUSH → IDLE when `flush_cnt == 0`.
- Flush counter:
  - Loaded with N-2 on entry to FLUSH.
  - Decremented each FLUSH cycle.
  - FLUSH therefore lasts N-1 cycles, during which zeros are shifted in.
- `k_cnt_o`:
  - Increments on each `acc`.
  - Cleared to 0 on the FLUSH→IDLE transition.
  - Holds its value through FLUSH.
- `tile_done_o` is asserted in the first IDLE cycle after FLUSH, combinationally decoded from a registered flag. A new tile may be accepted in that same cycle.
- `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - `a_o`, `b_o` all zero.
  - State IDLE, `ready_o` = 1, `busy_o` = 0.
  - `k_cnt_o` = 0, `tile_done_o` = 0.
  - All skew registers zero.
- Latency: a slice accepted at edge e appears on lane i after edge e+i, i.e. lane 0 is visible in the cycle following e.
- A last slice accepted at edge e0:
  - FLUSH occupies the cycles after edges e0 … e0+N-2.
  - IDLE with `tile_done_o` = 1 follows edge e0+N-1, coinciding with lane N-1 presenting that slice.
- Back-to-back: in the `tile_done_o` cycle, a new first slice can be accepted. The dead time between tiles is N-1 cycles (FLUSH).
- `valid_i` low in IDLE: no state change; zeros continue to shift.
- Reset asserted mid-tile: immediate asynchronous clear of all registers and outputs. No `tile_done_o` is issued for the aborted tile.
- `valid_i` with `last_i` while `ready_o` = 0 (in FLUSH): the slice is ignored. The upstream must hold it until `ready_o` returns.

## Test plan
- N=4, reset, then idle for 5 cycles → `a_o`/`b_o` are 0, `ready_o` = 1, `busy_o` = 0, `tile_done_o` never asserts.
- 4 consecutive slices with A column k = {k+1, k+1, k+1, k+1}, `last_i` on the 4th → `a_o[i]` shows 1, 2, 3, 4 starting i+1 cycles after the first accept. FLUSH lasts 3 cycles with `ready_o` = 0. `tile_done_o` pulses once while `a_o[3]` = 4. `k_cnt_o` reads 4 in FLUSH and 0 after.
- Same tile with `valid_i` dropped for 2 cycles after slice 2 → lane outputs contain two zero slices between slice values 2 and 3, and `tile_done_o` arrives 2 cycles later than in the previous scenario.
- `MAX_K` = 3 with `last_i` never set → the 3rd accept forces FLUSH, and `tile_done_o` fires 3 cycles after that accept.
- Tile 2 presented with `valid_i` held through FLUSH → no accept in FLUSH. First accept happens in the `tile_done_o` cycle, and lane 0 shows tile 2 slice 0 on the next cycle.
- `rst_i` pulsed mid-STREAM after 2 slices → outputs and `k_cnt_o` are 0 immediately, state is IDLE, and no `tile_done_o` is issued.
